data_mem_ws: RTL and testbench
==============================

Name: data_mem_ws

Overview:
- Parametrised successor to the single-cycle word data memory.
- Byte-addressed, little-endian, with byte, halfword and word loads and stores.
- Loads are sign- or zero-extended. Misaligned accesses are detected and blocked.
- A configurable wait-state FSM models slow memory. It stalls the CPU pipeline until each access completes.
- Sits in the MEM stage and replaces the combinational data memory.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two.
- WAIT_CYCLES, 2, extra wait states per access (0..15).
- ADDR_W, 32, byte address width.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  ADDR_W  byte address.
- writedata  input  32  store data; the low bits are used for sb/sh.
- memread  input  1  load request.
- memwrite  input  1  store request.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_ld  input  1  1 = zero-extend loads, 0 = sign-extend.
- readdata  output  32  registered load result; held until the next completed load.
- stall  output  1  freeze the pipeline; combinational.
- ready  output  1  one-cycle pulse marking access completion.
- misaligned  output  1  one-cycle pulse alongside ready when the access was misaligned.

Behaviour:
- Reset is asynchronous and active-high. It clears:
  - state to IDLE and all latched request fields;
  - readdata to 0, ready to 0, misaligned to 0;
  - any pending write, which is dropped with memory unchanged.
  Memory contents are not reset; all words are 0 at time zero.
- Word index = address[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- States are IDLE, WAIT and DONE.
- IDLE:
  - A request is memread or memwrite high.
  - On a request, latch address, writedata, size, unsigned_ld and the operation, and load the wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go to DONE; otherwise go to WAIT.
  - If memread and memwrite are both high, the write wins and the read is ignored.
- WAIT: decrement the counter. When the counter is 1 on a clock edge, go to DONE.
- DONE:
  - ready = 1 for exactly one cycle.
  - Return to IDLE unconditionally. Requests seen in DONE are ignored, because they belong to the instruction just completed.
- stall = (state==IDLE && request) || state==WAIT. stall is 0 in DONE.
- Latency: ready is asserted WAIT_CYCLES+1 cycles after the accept cycle.
- Commit edge: memory write and readdata update occur on the edge entering DONE, using the latched fields.
- Alignment:
  - A half access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]≠0.
  - A byte access is never misaligned.
- Misaligned access:
  - No memory write.
  - A misaligned load sets readdata to 0.
  - In DONE, misaligned = 1 together with ready.
- Store lanes (lane k = bits 8k+7:8k):
  - sb writes writedata[7:0] into lane addr[1:0].
  - sh writes writedata[15:0] into lanes addr[1]*2 and addr[1]*2+1.
  - sw writes all four lanes.
  - All other lanes are preserved.
- Load extraction:
  - lb takes lane addr[1:0] and extends it to 32 bits.
  - lh takes the halfword at addr[1] and extends it to 32 bits.
  - lw takes the full word.
  - Extension uses bit 7 or 15 for sign, or zeros when unsigned_ld=1.
- A store leaves readdata unchanged.
- Reset asserted in WAIT or DONE aborts the access: no write, and no ready pulse.

Test Plan:
- Word store/load, WAIT_CYCLES=2: sw 0xDEADBEEF to 0x10, then lw 0x10.
  - stall is high for 3 cycles per access.
  - ready pulses on the 4th cycle after accept.
  - readdata = 0xDEADBEEF.
- Byte lanes and sign extension (memory at 0x20 holds 0xDEADBEEF):
  - sb 0x80 to 0x21, then lw 0x20 gives 0xDEAD80EF.
  - lb 0x21 gives 0xFFFFFF80.
  - lbu 0x21 gives 0x00000080.
- Halfword access: sh 0x1234 to 0x32, then lw 0x30 gives 0x12340000. lh 0x32 gives 0x00001234.
- Misaligned access:
  - lw 0x13 pulses ready and misaligned, and readdata = 0.
  - sh to 0x31 leaves memory unchanged; a subsequent lw 0x30 returns its prior value.
- Reset mid-access: sw 0xAAAA5555 to 0x40 with reset pulsed during WAIT.
  - stall drops immediately and no ready pulse occurs.
  - lw 0x40 afterwards returns 0.
- Wrap and conflict, DEPTH=256:
  - sw 0x11 to address 0x400 is read back by lw 0x0.
  - memread and memwrite both high at 0x8 performs the write only, and readdata keeps its previous value.
  - With WAIT_CYCLES=0, stall is high for 1 cycle and ready pulses in the next cycle.

Source files
------------

// File: rtl/data_mem_ws.sv
// Byte-addressed little-endian data memory with a wait-state FSM for the MEM stage.
// Accesses commit on the edge entering DONE; stall holds the pipeline until then.
module data_mem_ws #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [31:0]       readdata,
  output logic              stall,
  output logic              ready,
  output logic              misaligned
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt;
  logic [LW-1:0] l_addr;
  logic [31:0]   l_wd;
  logic [1:0]    l_size;
  logic          l_uns, l_wr, l_rd;

  logic [LW-1:0] e_addr;
  logic [31:0]   e_wd;
  logic [1:0]    e_size;
  logic          e_uns, e_wr, e_rd, e_mis;
  logic          req, commit;
  logic [31:0]   old, sh, ld, wdata;
  logic [3:0]    wmask;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic unused_addr;
  assign unused_addr = ^address[ADDR_W-1:LW];

  function automatic logic mis_of(input logic [1:0] a, input logic [1:0] s);
    case (s)
      2'b00:   mis_of = 1'b0;
      2'b01:   mis_of = a[0];
      default: mis_of = (a != 2'b00);
    endcase
  endfunction

  assign req = memread | memwrite;

  // With zero wait states the commit edge is the accept edge, so the live
  // inputs must feed the datapath while idle; otherwise the latched copy does.
  always_comb begin
    e_addr = l_addr;
    e_wd   = l_wd;
    e_size = l_size;
    e_uns  = l_uns;
    e_wr   = l_wr;
    e_rd   = l_rd;
    if (state == S_IDLE) begin
      e_addr = address[LW-1:0];
      e_wd   = writedata;
      e_size = size;
      e_uns  = unsigned_ld;
      e_wr   = memwrite;
      e_rd   = memread & ~memwrite;
    end
  end

  assign e_mis  = mis_of(e_addr[1:0], e_size);
  assign commit = (state_n == S_DONE);
  assign old    = mem[e_addr[LW-1:2]];
  assign sh     = old >> {e_addr[1:0], 3'b000};

  always_comb begin
    wmask = 4'b1111;
    wdata = e_wd;
    ld    = sh;
    case (e_size)
      2'b00: begin
        wmask = 4'b0001 << e_addr[1:0];
        wdata = {4{e_wd[7:0]}};
        ld    = {{24{~e_uns & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        wmask = e_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{e_wd[15:0]}};
        ld    = {{16{~e_uns & sh[15]}}, sh[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req) state_n = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      l_addr   <= '0;
      l_wd     <= '0;
      l_size   <= '0;
      l_uns    <= 1'b0;
      l_wr     <= 1'b0;
      l_rd     <= 1'b0;
      readdata <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req) begin
        cnt    <= 4'(WAIT_CYCLES);
        l_addr <= address[LW-1:0];
        l_wd   <= writedata;
        l_size <= size;
        l_uns  <= unsigned_ld;
        l_wr   <= memwrite;
        l_rd   <= memread & ~memwrite;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && e_rd) readdata <= e_mis ? 32'h0 : ld;
    end
  end

  // Memory array carries no reset; the write is gated so a clock edge during
  // reset can never commit a store.
  always_ff @(posedge clock) begin
    if (commit && e_wr && !e_mis && !reset) begin
      for (int k = 0; k < 4; k++)
        if (wmask[k]) mem[e_addr[LW-1:2]][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign stall      = (state == S_IDLE && req) || state == S_WAIT;
  assign ready      = (state == S_DONE);
  assign misaligned = (state == S_DONE) && e_mis;
endmodule

// File: tb/tb_data_mem_ws.sv
// Bench for data_mem_ws: byte-array reference model, directed scenarios plus random traffic.
module tb_data_mem_ws;
  logic        clock = 0, reset = 1;
  logic [31:0] address = 0, writedata = 0;
  logic        memread = 0, memwrite = 0, unsigned_ld = 0;
  logic [1:0]  size = 0;
  logic [31:0] readdata;
  logic        stall, ready, misaligned;

  logic [31:0] a0 = 0, wd0 = 0, readdata0;
  logic        rd0 = 0, wr0 = 0, uns0 = 0, stall0, ready0, mis0;
  logic [1:0]  sz0 = 2'b10;

  data_mem_ws #(.DEPTH(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .address(address), .writedata(writedata),
    .memread(memread), .memwrite(memwrite), .size(size), .unsigned_ld(unsigned_ld),
    .readdata(readdata), .stall(stall), .ready(ready), .misaligned(misaligned));

  data_mem_ws #(.DEPTH(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clock(clock), .reset(reset), .address(a0), .writedata(wd0),
    .memread(rd0), .memwrite(wr0), .size(sz0), .unsigned_ld(uns0),
    .readdata(readdata0), .stall(stall0), .ready(ready0), .misaligned(mis0));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  logic [7:0]  mb [1024];
  logic [31:0] m_rd = 0;
  logic [31:0] exp_rd, obs_rd;
  bit          exp_mis, obs_mis;
  int          obs_stall, obs_rcyc;

  // Model the access from byte-level rules, then drive it and record what the DUT shows.
  task automatic run(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input bit uns);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_mis = (a % nb) != 0;
    if (wr) begin
      if (!exp_mis) for (int i = 0; i < nb; i++) mb[(a + i) % 1024] = wd[8*i +: 8];
    end else if (rd) begin
      if (exp_mis) m_rd = 0;
      else begin
        v = 0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[(a + i) % 1024];
        if (!uns && nb < 4 && v[8*nb-1]) for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        m_rd = v;
      end
    end
    exp_rd = m_rd;
    address = a; writedata = wd; memwrite = wr; memread = rd; size = sz; unsigned_ld = uns;
    obs_stall = 0; obs_rcyc = 0; obs_mis = 0; obs_rd = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (stall) obs_stall++;
      if (ready) begin obs_rcyc = c; obs_mis = misaligned; obs_rd = readdata; end
      @(posedge clock); #1;
      if (c == 1) begin memread = 0; memwrite = 0; end
      if (obs_rcyc != 0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    total++; if ({ready, misaligned, stall} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {ready, misaligned, stall}); end
    total++; if ({ready0, stall0} !== 2'b00) begin bad++; $display("FAIL reset_flags0 got=%b exp=00", {ready0, stall0}); end
    reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_word();
    run(1, 0, 32'h10, 32'hDEADBEEF, 2'b10, 0);
    total++; if (obs_stall != 3) begin bad++; $display("FAIL sw_stall got=%0d exp=3", obs_stall); end
    total++; if (obs_rcyc != 4) begin bad++; $display("FAIL sw_ready_cycle got=%0d exp=4", obs_rcyc); end
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL sw_readdata_kept got=%h exp=%h", obs_rd, exp_rd); end
    run(0, 1, 32'h10, 32'h0, 2'b10, 0);
    total++; if (obs_stall != 3 || obs_rcyc != 4) begin bad++; $display("FAIL lw_timing got=%0d/%0d exp=3/4", obs_stall, obs_rcyc); end
    total++; if (obs_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_word got=%h exp=deadbeef", obs_rd); end
  endtask

  task automatic test_bytes();
    run(1, 0, 32'h20, 32'hDEADBEEF, 2'b10, 0);
    run(1, 0, 32'h21, 32'h00000080, 2'b00, 0);
    run(0, 1, 32'h20, 32'h0, 2'b10, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL sb_lane got=%h exp=%h", obs_rd, exp_rd); end
    run(0, 1, 32'h21, 32'h0, 2'b00, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL lb_sign got=%h exp=%h", obs_rd, exp_rd); end
    run(0, 1, 32'h21, 32'h0, 2'b00, 1);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL lbu_zero got=%h exp=%h", obs_rd, exp_rd); end
  endtask

  task automatic test_half();
    run(1, 0, 32'h30, 32'h0, 2'b10, 0);
    run(1, 0, 32'h32, 32'hFFFF1234, 2'b01, 0);
    run(0, 1, 32'h30, 32'h0, 2'b10, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL sh_lanes got=%h exp=%h", obs_rd, exp_rd); end
    run(0, 1, 32'h32, 32'h0, 2'b01, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL lh got=%h exp=%h", obs_rd, exp_rd); end
    run(1, 0, 32'h34, 32'h0000C001, 2'b01, 0);
    run(0, 1, 32'h34, 32'h0, 2'b01, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL lh_sign got=%h exp=%h", obs_rd, exp_rd); end
  endtask

  task automatic test_misaligned();
    run(0, 1, 32'h13, 32'h0, 2'b10, 0);
    total++; if (obs_mis !== 1'b1 || obs_rcyc != 4) begin bad++; $display("FAIL lw_mis_flag got=%b/%0d exp=1/4", obs_mis, obs_rcyc); end
    total++; if (obs_rd !== 32'h0) begin bad++; $display("FAIL lw_mis_data got=%h exp=0", obs_rd); end
    run(1, 0, 32'h31, 32'h0000ABCD, 2'b01, 0);
    total++; if (obs_mis !== 1'b1) begin bad++; $display("FAIL sh_mis_flag got=%b exp=1", obs_mis); end
    run(0, 1, 32'h30, 32'h0, 2'b10, 0);
    total++; if (obs_rd !== exp_rd || obs_mis !== 1'b0) begin bad++; $display("FAIL sh_mis_nowrite got=%h exp=%h", obs_rd, exp_rd); end
  endtask

  task automatic test_reset_mid();
    bit saw_ready;
    address = 32'h40; writedata = 32'hAAAA5555; memwrite = 1; memread = 0; size = 2'b10;
    @(posedge clock); #1;
    memwrite = 0;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_mid_wait_stall got=%b exp=1", stall); end
    reset = 1; m_rd = 0;
    #1;
    total++; if (stall !== 1'b0 || readdata !== 32'h0) begin bad++; $display("FAIL rst_mid_async got=%b/%h exp=0/0", stall, readdata); end
    saw_ready = 0;
    repeat (2) begin @(negedge clock); if (ready) saw_ready = 1; end
    reset = 0;
    repeat (4) begin @(negedge clock); if (ready) saw_ready = 1; end
    total++; if (saw_ready) begin bad++; $display("FAIL rst_mid_ready got=1 exp=0"); end
    @(posedge clock); #1;
    run(0, 1, 32'h40, 32'h0, 2'b10, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL rst_mid_nowrite got=%h exp=%h", obs_rd, exp_rd); end
  endtask

  task automatic test_wrap_conflict();
    run(1, 0, 32'h400, 32'h11, 2'b10, 0);
    run(0, 1, 32'h0, 32'h0, 2'b10, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL wrap got=%h exp=%h", obs_rd, exp_rd); end
    run(1, 1, 32'h8, 32'h5A5AC3C3, 2'b10, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL conflict_keep got=%h exp=%h", obs_rd, exp_rd); end
    run(0, 1, 32'h8, 32'h0, 2'b10, 0);
    total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL conflict_write got=%h exp=%h", obs_rd, exp_rd); end
  endtask

  task automatic test_wait0();
    a0 = 32'h24; wd0 = 32'h13579BDF; wr0 = 1; rd0 = 0; sz0 = 2'b10;
    @(negedge clock);
    total++; if (stall0 !== 1'b1 || ready0 !== 1'b0) begin bad++; $display("FAIL w0_accept got=%b%b exp=10", stall0, ready0); end
    @(posedge clock); #1; wr0 = 0;
    @(negedge clock);
    total++; if (ready0 !== 1'b1 || stall0 !== 1'b0) begin bad++; $display("FAIL w0_ready got=%b%b exp=10", ready0, stall0); end
    @(posedge clock); #1; rd0 = 1;
    @(negedge clock);
    total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL w0_ld_stall got=%b exp=1", stall0); end
    @(posedge clock); #1; rd0 = 0;
    @(negedge clock);
    total++; if (ready0 !== 1'b1 || readdata0 !== 32'h13579BDF) begin bad++; $display("FAIL w0_load got=%b/%h exp=1/13579bdf", ready0, readdata0); end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 3);
      a  = 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3)) * 32'h400;
      run(op == 1 || op == 2, op != 1, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      total++; if (obs_stall != 3 || obs_rcyc != 4) begin bad++; $display("FAIL rnd_timing n=%0d got=%0d/%0d exp=3/4", n, obs_stall, obs_rcyc); end
      total++; if (obs_mis !== exp_mis) begin bad++; $display("FAIL rnd_mis n=%0d a=%h got=%b exp=%b", n, a, obs_mis, exp_mis); end
      total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL rnd_data n=%0d a=%h got=%h exp=%h", n, a, obs_rd, exp_rd); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    test_reset();
    test_word();
    test_bytes();
    test_half();
    test_misaligned();
    test_reset_mid();
    test_wrap_conflict();
    test_wait0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
